fetch_stage: RTL and testbench

Instruction fetch stage plus IF/ID pipeline register for the 5-stage RV32I pipeline. Owns the PC and issues one-outstanding fetches to instruction memory over a req/gnt/rvalid handshake. Loads fetched instructions into IF/ID under control of the hazard unit's pc_en/if_id_en, and redirects on EX-stage branch/jump flush. Drives the IF/ID rs1/rs2/valid fields that the hazard unit consumes.

---
 rtl/fetch_stage_pkg.sv | 32 +++
 rtl/fetch_stage_if_id_reg.sv | 71 +++++++
 rtl/fetch_stage.sv | 144 ++++++++++++++
 tb/tb_fetch_stage.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the fetch stage and pipeline registers:
// fetch FSM state encodings, the bubble instruction and RV32 field positions.
package fetch_stage_pkg;

  // Fetch FSM states (2-bit encoding)
  typedef enum logic [1:0] {
    FS_REQ  = 2'd0,  // request may be issued
    FS_WAIT = 2'd1,  // request accepted, waiting for rvalid
    FS_HOLD = 2'd2,  // response captured in hold buffer, waiting to advance
    FS_DROP = 2'd3   // outstanding response must be discarded (flushed)
  } fetch_state_e;

  // addi x0, x0, 0
  localparam logic [31:0] DEFAULT_NOP_INST = 32'h0000_0013;

  // RV32 register-source field positions
  localparam int RS1_LSB = 15;
  localparam int RS1_MSB = 19;
  localparam int RS2_LSB = 20;
  localparam int RS2_MSB = 24;

  // Force an address onto a 32-bit word boundary
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

  // Next sequential PC, 32-bit modulo
  function automatic logic [31:0] pc_inc(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// Generic IF/ID-style pipeline register: load, bubble, flush and hold
// controls, plus rs1/rs2 field extraction for the hazard unit.
// Priority: flush > load > bubble > hold.
module if_id_reg
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] NOP_INST = DEFAULT_NOP_INST
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        load,
  input  logic        bubble,
  input  logic [31:0] load_pc,
  input  logic [31:0] load_inst,
  output logic [31:0] pc,
  output logic [31:0] inst,
  output logic        valid,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2
);

  logic [31:0] pc_r;
  logic [31:0] inst_r;
  logic        valid_r;
  logic [31:0] pc_next_s;
  logic [31:0] inst_next_s;
  logic        valid_next_s;

  // Select the next register contents from the control priority chain
  always_comb begin
    pc_next_s    = pc_r;
    inst_next_s  = inst_r;
    valid_next_s = valid_r;
    if (flush) begin
      inst_next_s  = NOP_INST;
      valid_next_s = 1'b0;
    end else if (load) begin
      pc_next_s    = load_pc;
      inst_next_s  = load_inst;
      valid_next_s = 1'b1;
    end else if (bubble) begin
      inst_next_s  = NOP_INST;
      valid_next_s = 1'b0;
    end else begin
      pc_next_s    = pc_r;
      inst_next_s  = inst_r;
      valid_next_s = valid_r;
    end
  end

  // Pipeline register state, bubble contents on reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_r    <= 32'h0000_0000;
      inst_r  <= NOP_INST;
      valid_r <= 1'b0;
    end else begin
      pc_r    <= pc_next_s;
      inst_r  <= inst_next_s;
      valid_r <= valid_next_s;
    end
  end

  assign pc    = pc_r;
  assign inst  = inst_r;
  assign valid = valid_r;
  assign rs1   = inst_r[RS1_MSB:RS1_LSB];
  assign rs2   = inst_r[RS2_MSB:RS2_LSB];

endmodule

// File: rtl/fetch_stage.sv
// RV32I instruction fetch stage: owns the PC, issues one-outstanding fetches
// over req/gnt/rvalid, buffers a response while the pipeline is stalled,
// and feeds the IF/ID register. EX-stage flush redirects the PC and kills
// both the in-flight fetch and the IF/ID contents.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = DEFAULT_NOP_INST
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pc_en,
  input  logic        if_id_en,
  input  logic        flush,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_inst,
  output logic        if_id_valid,
  output logic [4:0]  if_id_rs1,
  output logic [4:0]  if_id_rs2
);

  fetch_state_e state_r;
  fetch_state_e state_next_s;
  logic [31:0]  pc_r;
  logic [31:0]  pc_next_s;
  logic [31:0]  hold_buf_r;
  logic [31:0]  hold_buf_next_s;
  logic         advance_s;
  logic         deliver_s;
  logic [31:0]  deliver_inst_s;
  logic         bubble_s;

  assign advance_s = pc_en & if_id_en;

  // Requests only from REQ; a flush in the same cycle suppresses it so the
  // old-path address is never accepted, and reset holds it low.
  assign imem_req  = (state_r == FS_REQ) & ~flush & ~rst;
  assign imem_addr = pc_r;

  // Fetch FSM next state, PC update, hold buffer and delivery decision
  always_comb begin
    state_next_s    = state_r;
    pc_next_s       = pc_r;
    hold_buf_next_s = hold_buf_r;
    deliver_s       = 1'b0;
    deliver_inst_s  = imem_rdata;
    if (flush) begin
      pc_next_s       = word_align(redirect_pc);
      hold_buf_next_s = NOP_INST;
      case (state_r)
        FS_WAIT: state_next_s = imem_rvalid ? FS_REQ : FS_DROP;
        FS_DROP: state_next_s = imem_rvalid ? FS_REQ : FS_DROP;
        FS_HOLD: state_next_s = FS_REQ;
        FS_REQ:  state_next_s = FS_REQ;
        default: state_next_s = FS_REQ;
      endcase
    end else begin
      case (state_r)
        FS_REQ: begin
          if (imem_gnt) begin
            state_next_s = FS_WAIT;
          end else begin
            state_next_s = FS_REQ;
          end
        end
        FS_WAIT: begin
          if (imem_rvalid) begin
            if (advance_s) begin
              deliver_s      = 1'b1;
              deliver_inst_s = imem_rdata;
              pc_next_s      = pc_inc(pc_r);
              state_next_s   = FS_REQ;
            end else begin
              hold_buf_next_s = imem_rdata;
              state_next_s    = FS_HOLD;
            end
          end else begin
            state_next_s = FS_WAIT;
          end
        end
        FS_HOLD: begin
          if (advance_s) begin
            deliver_s       = 1'b1;
            deliver_inst_s  = hold_buf_r;
            pc_next_s       = pc_inc(pc_r);
            hold_buf_next_s = NOP_INST;
            state_next_s    = FS_REQ;
          end else begin
            state_next_s = FS_HOLD;
          end
        end
        FS_DROP: begin
          if (imem_rvalid) begin
            state_next_s = FS_REQ;
          end else begin
            state_next_s = FS_DROP;
          end
        end
        default: state_next_s = FS_REQ;
      endcase
    end
  end

  // A cycle that lets IF/ID load but delivers nothing inserts a bubble
  assign bubble_s = if_id_en & ~deliver_s;

  // FSM state, PC and hold buffer registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= FS_REQ;
      pc_r       <= RESET_PC;
      hold_buf_r <= NOP_INST;
    end else begin
      state_r    <= state_next_s;
      pc_r       <= pc_next_s;
      hold_buf_r <= hold_buf_next_s;
    end
  end

  if_id_reg #(
    .NOP_INST (NOP_INST)
  ) u_if_id_reg (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .load      (deliver_s),
    .bubble    (bubble_s),
    .load_pc   (pc_r),
    .load_inst (deliver_inst_s),
    .pc        (if_id_pc),
    .inst      (if_id_inst),
    .valid     (if_id_valid),
    .rs1       (if_id_rs1),
    .rs2       (if_id_rs2)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage. A transaction-level model (outstanding
// fetch / pending response / killed flag) predicts every output each cycle;
// literal checks at key points pin the model to hand-computed values.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pc_en = 1'b0;
  logic        if_id_en = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_inst;
  logic        if_id_valid;
  logic [4:0]  if_id_rs1;
  logic [4:0]  if_id_rs2;

  int errors = 0;
  int checks = 0;

  localparam logic [31:0] NOP = 32'h0000_0013;

  fetch_stage dut (
    .clk         (clk),
    .rst         (rst),
    .pc_en       (pc_en),
    .if_id_en    (if_id_en),
    .flush       (flush),
    .redirect_pc (redirect_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .if_id_pc    (if_id_pc),
    .if_id_inst  (if_id_inst),
    .if_id_valid (if_id_valid),
    .if_id_rs1   (if_id_rs1),
    .if_id_rs2   (if_id_rs2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit          m_out;    // a fetch was accepted and its response is still due
  bit          m_kill;   // that response belongs to a flushed path
  bit          m_pend;   // a response is parked waiting for the pipeline
  logic [31:0] m_pdata;
  logic [31:0] m_pc;
  logic [31:0] m_ipc;
  logic [31:0] m_iinst;
  bit          m_ival;

  always @(posedge clk or posedge rst) begin
    bit adv, got, acc, dlv;
    logic [31:0] d;
    if (rst) begin
      m_out = 0; m_kill = 0; m_pend = 0; m_pdata = NOP;
      m_pc = 32'h0; m_ipc = 32'h0; m_iinst = NOP; m_ival = 0;
    end else begin
      adv = pc_en && if_id_en;
      got = imem_rvalid && m_out;
      acc = !(m_out || m_pend) && !flush && imem_gnt;
      dlv = 0;
      d   = 32'h0;
      if (flush) begin
        if (got) begin m_out = 0; m_kill = 0; end
        else if (m_out) m_kill = 1;
        m_pend = 0;
        m_pc   = {redirect_pc[31:2], 2'b00};
        m_ival = 0; m_iinst = NOP;
      end else begin
        if (m_pend && adv) begin dlv = 1; d = m_pdata; m_pend = 0; end
        else if (got && !m_kill && adv) begin dlv = 1; d = imem_rdata; end
        else if (got && !m_kill) begin m_pend = 1; m_pdata = imem_rdata; end
        if (got) begin m_out = 0; m_kill = 0; end
        if (dlv) begin
          m_ipc = m_pc; m_iinst = d; m_ival = 1; m_pc = m_pc + 32'd4;
        end else if (if_id_en) begin
          m_ival = 0; m_iinst = NOP;
        end
        if (acc) begin m_out = 1; m_kill = 0; end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (rst) begin
      chk("req_in_reset", {31'b0, imem_req}, 32'd0);
    end else begin
      chk("imem_req", {31'b0, imem_req}, {31'b0, (!(m_out || m_pend) && !flush)});
      chk("imem_addr", imem_addr, m_pc);
      chk("if_id_valid", {31'b0, if_id_valid}, {31'b0, m_ival});
      chk("if_id_inst", if_id_inst, m_iinst);
      if (m_ival) chk("if_id_pc", if_id_pc, m_ipc);
      chk("if_id_rs1", {27'b0, if_id_rs1}, {27'b0, m_iinst[19:15]});
      chk("if_id_rs2", {27'b0, if_id_rs2}, {27'b0, m_iinst[24:20]});
    end
  end

  // One cycle of directed stimulus, returns 1 time unit after the edge
  task automatic cyc(input bit pe, input bit ie, input bit fl, input logic [31:0] rpc,
                     input bit g, input bit rv, input logic [31:0] rd);
    pc_en = pe; if_id_en = ie; flush = fl; redirect_pc = rpc;
    imem_gnt = g; imem_rvalid = rv; imem_rdata = rd;
    @(posedge clk);
    #1;
  endtask

  task automatic lit_ifid(input string tag, input logic [31:0] pc, input logic [31:0] inst, input bit v);
    chk({tag, "_valid"}, {31'b0, if_id_valid}, {31'b0, v});
    chk({tag, "_inst"}, if_id_inst, inst);
    chk({tag, "_pc"}, if_id_pc, pc);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", {31'b0, if_id_valid}, 32'd0);
    chk("rst_inst", if_id_inst, NOP);
    chk("rst_pc", if_id_pc, 32'h0);
    chk("rst_addr", imem_addr, 32'h0);
    rst = 1'b0;

    // 1: streaming fetch, 1-cycle memory
    cyc(1, 1, 0, 0, 1, 0, 0);
    cyc(1, 1, 0, 0, 0, 1, 32'h0050_0093);
    lit_ifid("t1a", 32'h0, 32'h0050_0093, 1);
    chk("t1_rs1", {27'b0, if_id_rs1}, 32'd0);
    chk("t1_rs2", {27'b0, if_id_rs2}, 32'd5);
    chk("t1_addr4", imem_addr, 32'h4);
    cyc(1, 1, 0, 0, 1, 0, 0);
    cyc(1, 1, 0, 0, 0, 1, 32'h0060_0113);
    lit_ifid("t1b", 32'h4, 32'h0060_0113, 1);
    chk("t1_addr8", imem_addr, 32'h8);

    // 2: stall while the response arrives
    cyc(1, 1, 0, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 0, 1, 32'h0020_81B3);
    cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    lit_ifid("t2_held", 32'h4, NOP, 0);
    chk("t2_addr_held", imem_addr, 32'h8);
    cyc(1, 1, 0, 0, 0, 0, 0);
    lit_ifid("t2_rel", 32'h8, 32'h0020_81B3, 1);
    chk("t2_rs1", {27'b0, if_id_rs1}, 32'd1);
    chk("t2_rs2", {27'b0, if_id_rs2}, 32'd2);
    chk("t2_addr", imem_addr, 32'hC);

    // 3: flush in WAIT, late response discarded
    cyc(1, 1, 0, 0, 1, 0, 0);
    cyc(1, 1, 1, 32'h100, 0, 0, 0);
    cyc(1, 1, 0, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0, 1, 32'hDEAD_BEEF);
    chk("t3_valid", {31'b0, if_id_valid}, 32'd0);
    chk("t3_inst", if_id_inst, NOP);
    chk("t3_addr", imem_addr, 32'h100);
    cyc(1, 1, 0, 0, 1, 0, 0);
    cyc(1, 1, 0, 0, 0, 1, 32'h00A0_0513);
    lit_ifid("t3_new", 32'h100, 32'h00A0_0513, 1);

    // 4: flush and rvalid together while stalled; redirect low bits dropped
    cyc(1, 1, 0, 0, 1, 0, 0);
    cyc(1, 0, 1, 32'h203, 0, 1, 32'h1111_1111);
    chk("t4_valid", {31'b0, if_id_valid}, 32'd0);
    chk("t4_inst", if_id_inst, NOP);
    chk("t4_addr", imem_addr, 32'h200);
    cyc(1, 1, 0, 0, 1, 0, 0);
    cyc(1, 1, 0, 0, 0, 1, 32'h00C0_0613);
    lit_ifid("t4_new", 32'h200, 32'h00C0_0613, 1);

    // 5: grant withheld, bubbles inserted
    for (int i = 0; i < 5; i++) cyc(1, 1, 0, 0, 0, 0, 0);
    chk("t5_addr", imem_addr, 32'h204);
    chk("t5_valid", {31'b0, if_id_valid}, 32'd0);
    chk("t5_inst", if_id_inst, NOP);
    cyc(1, 1, 0, 0, 1, 0, 0);

    // 6: async reset mid-WAIT, stray rvalid afterwards
    #2;
    rst = 1'b1;
    #1;
    chk("t6_req", {31'b0, imem_req}, 32'd0);
    chk("t6_addr", imem_addr, 32'h0);
    lit_ifid("t6_rst", 32'h0, NOP, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc(1, 1, 0, 0, 0, 1, 32'hBADB_AD00);
    chk("t6_stray_addr", imem_addr, 32'h0);
    chk("t6_stray_valid", {31'b0, if_id_valid}, 32'd0);
    cyc(1, 1, 0, 0, 1, 0, 0);
    cyc(1, 1, 0, 0, 0, 1, 32'h0000_0093);
    lit_ifid("t6_new", 32'h0, 32'h0000_0093, 1);

    // 7: PC wraps modulo 2^32
    cyc(1, 1, 0, 0, 1, 0, 0);
    cyc(1, 1, 1, 32'hFFFF_FFFC, 0, 0, 0);
    cyc(1, 1, 0, 0, 0, 1, 32'h1234_5678);
    chk("t7_addr", imem_addr, 32'hFFFF_FFFC);
    cyc(1, 1, 0, 0, 1, 0, 0);
    cyc(1, 1, 0, 0, 0, 1, 32'h0010_0073);
    lit_ifid("t7_new", 32'hFFFF_FFFC, 32'h0010_0073, 1);
    chk("t7_wrap", imem_addr, 32'h0);

    cyc(0, 0, 0, 0, 0, 0, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
